wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM->WB write-back interface: a 32-entry general-purpose register file.
- It commits the WB-stage result (ife_wb / Ri_wb / write_wb) on the clock edge.
- It serves two combinational read ports to the ID stage, with WB->ID write-first bypass, plus a debug read port.
- It keeps a commit counter that benches and debug logic use to track retired register writes.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- BYPASS, 1, 1 = a same-cycle WB write is visible on the ID read ports; 0 = read returns the stored value only
- CNT_W, 16, width of the commit counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- ife_wb  in  1  write enable from WB stage
- Ri_wb  in  ADDR_W  destination register index from WB stage
- write_wb  in  DATA_W  write-back data from WB stage
- Rs_id  in  ADDR_W  read index A (ID stage)
- Rt_id  in  ADDR_W  read index B (ID stage)
- rs_data  out  DATA_W  read data A
- rt_data  out  DATA_W  read data B
- dbg_addr  in  ADDR_W  debug read index
- dbg_data  out  DATA_W  debug read data; no bypass
- wr_count  out  CNT_W  number of committed writes
- wr_last  out  ADDR_W  index of the most recently committed register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - rst_n low clears all registers to 0, wr_count to 0 and wr_last to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, writes are ignored.
  - Reset release is synchronous in effect: the first commit can happen on the first rising edge with rst_n high.
- Write:
  - On a rising clk with ife_wb=1 and Ri_wb!=0: reg[Ri_wb] <= write_wb, wr_count <= wr_count+1, wr_last <= Ri_wb.
  - ife_wb=0, or Ri_wb=0: no state change at all; the counter does not increment.
  - Latency: the written value is readable from storage from the cycle after the edge.
- Register 0 is hardwired to 0. Reads of index 0 return 0 on all ports regardless of the bypass path or the stored contents.
- Read (combinational, zero latency):
  - rs_data = 0 if Rs_id==0.
  - Otherwise, if BYPASS=1 and ife_wb=1 and Ri_wb==Rs_id, rs_data = write_wb.
  - Otherwise rs_data = reg[Rs_id].
  - rt_data follows the same rule on Rt_id.
  - Both ports may address the same register and must return identical data.
  - dbg_data = reg[dbg_addr], with 0 for index 0 and never bypassed.
- Simultaneous events:
  - A write to X and a read of X in the same cycle return the new value when BYPASS=1 and the old value when BYPASS=0.
  - Reads of other indices are unaffected.
- Counter: wr_count wraps from 2**CNT_W-1 to 0 without saturating. There is no overflow flag.
- Reset mid-operation: asserting rst_n while ife_wb=1 drops that write. All outputs derived from storage read 0 (bypass still applies to rs_data/rt_data when BYPASS=1 and ife_wb=1, since the read path is combinational).
- X-safety: index inputs are always in range for power-of-two depth. No out-of-range handling is needed.
- Writes on every cycle are supported back-to-back. There is no stall or handshake; the WB stage is the sole writer.

Test Plan:
- Reset: hold rst_n=0, then release.
  -> All dbg_data reads 0..31 return 0; wr_count=0; wr_last=0.
- Basic write/read: write reg5=0xDEADBEEF (ife_wb=1, Ri_wb=5), then next cycle Rs_id=5, Rt_id=5.
  -> rs_data = rt_data = 0xDEADBEEF; wr_count=1; wr_last=5.
- Bypass: with reg7=0x11, in the same cycle drive ife_wb=1, Ri_wb=7, write_wb=0x22, Rs_id=7, Rt_id=3.
  -> Before the edge, rs_data=0x22 and dbg_data(7)=0x11.
  -> After the edge, dbg_data(7)=0x22.
  -> With BYPASS=0, rs_data=0x11 before the edge.
- r0 protection: write Ri_wb=0, write_wb=0xFFFFFFFF with ife_wb=1, and read Rs_id=0 in the same cycle.
  -> rs_data=0 both before and after the edge; wr_count unchanged.
- Disabled write: ife_wb=0, Ri_wb=9, write_wb=0x1234.
  -> reg9 unchanged; wr_count unchanged.
- Counter wrap and async reset: with CNT_W=4, perform 17 writes to reg1.
  -> wr_count=1 after wrap.
  -> Then pulse rst_n low mid-cycle between edges: reg1 and wr_count clear to 0 immediately, before the next edge.

Source files
------------

// File: rtl/wb_regfile.sv
// 32-entry GPR file fed by the WB stage. Two combinational ID read ports with optional write-first bypass,
// plus a debug port. Entry 0 reads as zero. A commit counter tracks retired writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ife_wb,
    input  logic [ADDR_W-1:0] Ri_wb,
    input  logic [DATA_W-1:0] write_wb,
    input  logic [ADDR_W-1:0] Rs_id,
    input  logic [ADDR_W-1:0] Rt_id,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic [ADDR_W-1:0] wr_last
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              commit;

    assign commit = ife_wb && (Ri_wb != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_count <= '0;
            wr_last  <= '0;
        end else if (commit) begin
            mem[Ri_wb] <= write_wb;
            wr_count   <= wr_count + CNT_W'(1);
            wr_last    <= Ri_wb;
        end
    end

    // Bypass only matters for a real commit; a write aimed at r0 must never leak onto the read ports.
    always_comb begin
        rs_data = '0;
        if (Rs_id != '0) begin
            if ((BYPASS != 0) && commit && (Ri_wb == Rs_id)) begin
                rs_data = write_wb;
            end else begin
                rs_data = mem[Rs_id];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (Rt_id != '0) begin
            if ((BYPASS != 0) && commit && (Ri_wb == Rt_id)) begin
                rt_data = write_wb;
            end else begin
                rt_data = mem[Rt_id];
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        if (dbg_addr != '0) begin
            dbg_data = mem[dbg_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a bypassing instance with a 4-bit counter and a non-bypassing instance share stimulus.
// Directed vector table, wrap/reset sequences, then random traffic against an array model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ife_wb;
    logic [4:0]  Ri_wb, Rs_id, Rt_id, dbg_addr;
    logic [31:0] write_wb;
    logic [31:0] rs_data, rt_data, dbg_data;
    logic [3:0]  wr_count;
    logic [4:0]  wr_last;
    logic [31:0] rs_nb, rt_nb, dbg_nb;
    logic [15:0] cnt_nb;
    logic [4:0]  last_nb;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ife_wb(ife_wb), .Ri_wb(Ri_wb), .write_wb(write_wb),
        .Rs_id(Rs_id), .Rt_id(Rt_id), .rs_data(rs_data), .rt_data(rt_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count), .wr_last(wr_last)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(16)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ife_wb(ife_wb), .Ri_wb(Ri_wb), .write_wb(write_wb),
        .Rs_id(Rs_id), .Rt_id(Rt_id), .rs_data(rs_nb), .rt_data(rt_nb),
        .dbg_addr(dbg_addr), .dbg_data(dbg_nb), .wr_count(cnt_nb), .wr_last(last_nb)
    );

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
        ife_wb = we; Ri_wb = wa; write_wb = wd; Rs_id = ra; Rt_id = rb; dbg_addr = da;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra, rb, da;
        logic [31:0] ers, ert, edbg, ers_nb;
        logic [3:0]  ecnt;
        logic [4:0]  elast;
    } vec_t;

    vec_t tbl[8];

    // Reference state: plain array of register contents plus commit bookkeeping.
    logic [31:0] mdl [32];
    int unsigned mcnt;
    logic [4:0]  mlast;

    function automatic logic [31:0] mrd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && ife_wb && Ri_wb == a) return write_wb;
        return mdl[a];
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt  = 0;
        mlast = 5'd0;
    endtask

    initial begin
        //          we wa   wd            ra rb da  ers           ert           edbg          ers_nb        cnt last
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        4'd0, 5'd0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'd1, 5'd5};
        tbl[2] = '{1'b1, 5'd7, 32'h11,       5'd0, 5'd0, 5'd7, 32'h0,        32'h0,        32'h0,        32'h0,        4'd1, 5'd5};
        tbl[3] = '{1'b1, 5'd7, 32'h22,       5'd7, 5'd3, 5'd7, 32'h22,       32'h0,        32'h11,       32'h11,       4'd2, 5'd7};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 5'd7, 32'h22,       32'h22,       32'h22,       32'h22,       4'd3, 5'd7};
        tbl[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        4'd3, 5'd7};
        tbl[6] = '{1'b0, 5'd9, 32'h1234,     5'd0, 5'd9, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        4'd3, 5'd7};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd5, 5'd9, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        4'd3, 5'd7};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1 chk($sformatf("reset_dbg%0d", i), dbg_data, 32'h0);
        end
        chk("reset_cnt", 32'(wr_count), 32'h0);
        chk("reset_last", 32'(wr_last), 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].da);
            @(negedge clk);
            chk($sformatf("vec%0d_rs", i), rs_data, tbl[i].ers);
            chk($sformatf("vec%0d_rt", i), rt_data, tbl[i].ert);
            chk($sformatf("vec%0d_dbg", i), dbg_data, tbl[i].edbg);
            chk($sformatf("vec%0d_rs_nobypass", i), rs_nb, tbl[i].ers_nb);
            chk($sformatf("vec%0d_cnt", i), 32'(wr_count), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d_last", i), 32'(wr_last), 32'(tbl[i].elast));
            @(posedge clk);
            #1;
        end

        // Counter wrap: 17 commits into a 4-bit counter from zero.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd1, 32'(100 + i), 5'd0, 5'd0, 5'd0);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd1);
        @(negedge clk);
        chk("wrap_cnt", 32'(wr_count), 32'd1);
        chk("wrap_cnt_wide", 32'(cnt_nb), 32'd17);
        chk("wrap_dbg1", dbg_data, 32'd116);
        chk("wrap_last", 32'(wr_last), 32'd1);

        // Asynchronous reset between edges clears storage and counter immediately.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_dbg1", dbg_data, 32'h0);
        chk("arst_rs1", rs_data, 32'h0);
        chk("arst_cnt", 32'(wr_count), 32'h0);
        drive(1'b1, 5'd2, 32'hABCD, 5'd2, 5'd0, 5'd2);
        #1;
        chk("arst_bypass_rs", rs_data, 32'hABCD);
        chk("arst_nobypass_rs", rs_nb, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd2);
        @(negedge clk);
        chk("arst_write_dropped", dbg_data, 32'h0);
        chk("arst_cnt_after", 32'(wr_count), 32'h0);
        @(posedge clk);
        #1;

        // Random traffic against the array model.
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  wa, ra, rb, da;
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
            da = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(we, wa, $urandom, ra, rb, da);
            @(negedge clk);
            chk("rnd_rs", rs_data, mrd(ra, 1'b1));
            chk("rnd_rt", rt_data, mrd(rb, 1'b1));
            chk("rnd_dbg", dbg_data, mrd(da, 1'b0));
            chk("rnd_rs_nobypass", rs_nb, mrd(ra, 1'b0));
            chk("rnd_rt_nobypass", rt_nb, mrd(rb, 1'b0));
            chk("rnd_cnt", 32'(wr_count), mcnt % 16);
            chk("rnd_cnt_wide", 32'(cnt_nb), mcnt % 65536);
            chk("rnd_last", 32'(wr_last), 32'(mlast));
            @(posedge clk);
            if (we && wa != 0) begin
                mdl[wa] = write_wb;
                mcnt++;
                mlast = wa;
            end
            #1;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
